master_in_burst: RTL and testbench
==================================

MASTER_IN_BURST -- requirements
Module: master_in_burst

Interface
REQ-001 The block SHALL have these parameters:
- DATA_WIDTH, 8, bits per received word.
- BURST_W, 12, width of burst_num.
- FIFO_DEPTH, 4, receive FIFO entries; power of 2, at least 2.
- MSB_FIRST, 0, serial bit order: 0 means the first bit received lands in bit 0; 1 means it lands in bit DATA_WIDTH-1.
- TIMEOUT, 255, cycles to wait for slave_valid before abort; minimum 1.
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- tx_done  in  1  address/command phase complete; sampled only in IDLE.
- instruction  in  2  2'b11 = read; all other codes are ignored.
- burst_num  in  BURST_W  additional words after the first; a transaction moves burst_num+1 words.
- slave_valid  in  1  slave is ready to stream a word.
- rx_data  in  1  serial data, one bit per cycle.
- data_ready  in  1  consumer accepts the FIFO head.
- master_ready  out  1  master can accept the next word.
- new_rx  out  1  one-cycle pulse when a word is pushed to the FIFO.
- data  out  DATA_WIDTH  FIFO head word, first-word fall-through.
- data_valid  out  1  FIFO not empty.
- fifo_level  out  clog2(FIFO_DEPTH)+1  number of FIFO entries in use.
- rx_done  out  1  one-cycle pulse when a transaction completes.
- timeout_err  out  1  one-cycle pulse on timeout abort.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, WAIT, RECV and DONE.
REQ-004 IDLE: when tx_done=1 and instruction=2'b11, the block SHALL latch burst_num into words_left, clear the timeout counter and enter WAIT; otherwise it SHALL stay in IDLE.
REQ-005 master_ready SHALL equal (state==WAIT && fifo_level<FIFO_DEPTH), and SHALL be 0 in every other state.
REQ-006 WAIT: when slave_valid=1 and master_ready=1, the block SHALL enter RECV with bit_cnt=0.
REQ-007 RECV SHALL sample rx_data on each of the next DATA_WIDTH rising edges, the first sample falling one cycle after the WAIT->RECV transition, and place bits according to MSB_FIRST.
REQ-008 On the last bit, the block SHALL push the assembled word into the FIFO and assert new_rx in the following cycle.
REQ-009 After the push: if words_left==0 the block SHALL enter DONE; otherwise it SHALL decrement words_left and enter WAIT, giving a minimum gap of one cycle between words.
REQ-010 DONE SHALL assert rx_done for exactly one cycle, then return to IDLE.
REQ-011 In RECV, slave_valid, tx_done and instruction SHALL be ignored; a word, once started, always completes.
REQ-012 In WAIT, the timeout counter SHALL increment on each cycle with slave_valid=0, and SHALL clear on each cycle with slave_valid=1.
REQ-013 When the timeout counter reaches TIMEOUT, the block SHALL pulse timeout_err for one cycle and return to IDLE; rx_done SHALL NOT pulse, and FIFO contents SHALL be retained.
REQ-014 The FIFO SHALL pop when data_valid=1 and data_ready=1.
REQ-015 A simultaneous push and pop SHALL leave fifo_level unchanged.
REQ-016 A pop on an empty FIFO SHALL be ignored.
REQ-017 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 A push SHALL never occur while the FIFO is full; this is guaranteed by REQ-005, since only one word is ever in flight.
REQ-019 burst_num at its all-ones value SHALL transfer 2^BURST_W words with no counter overflow.
REQ-020 tx_done asserted outside IDLE SHALL have no effect.

Reset
REQ-021 While reset=0, asynchronously:
- the state SHALL be IDLE;
- the FIFO SHALL be emptied (fifo_level=0);
- the bit, word and timeout counters SHALL be 0;
- master_ready, new_rx, data_valid, rx_done and timeout_err SHALL be 0, and data SHALL be all zeros.
REQ-022 Reset asserted mid-word or mid-burst SHALL discard the partial word, and no new_rx or rx_done SHALL follow reset release.

Verification (DATA_WIDTH=8, MSB_FIRST=0, FIFO_DEPTH=4 unless stated)
REQ-023 Single read: instruction=11, burst_num=0, tx_done=1, slave_valid=1, bits 0,1,1,0,1,0,1,1 -> one new_rx, data=8'hD6, data_valid=1, rx_done one cycle after new_rx.
REQ-024 Burst: burst_num=2, data_ready=1, words 8'h5E, 8'hD4, 8'hDE -> three new_rx pulses; data pops in the same order; rx_done after the third word; fifo_level returns to 0.
REQ-025 Backpressure: burst_num=5, data_ready=0 -> master_ready drops after 4 words with fifo_level=4; raising data_ready resumes the transfer, all 6 words arrive in order, then rx_done.
REQ-026 Timeout: TIMEOUT=16, read issued with slave_valid held 0 -> timeout_err pulses 16 cycles after entry to WAIT; state is IDLE; rx_done stays 0.
REQ-027 Reset mid-word: reset=0 after the 4th bit -> all outputs 0 immediately; after release, no new_rx; a fresh read then works per REQ-023.
REQ-028 Ignored command: instruction=01 with tx_done=1 -> block stays in IDLE with master_ready=0; MSB_FIRST=1 with the REQ-023 bits -> data=8'h6B.

Source files
------------

// File: rtl/master_in_burst.sv
// rtl/master_in_burst.sv - serial burst read receiver with timeout abort and a first-word fall-through FIFO
module master_in_burst #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_W    = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tx_done,
  input  logic [1:0]                    instruction,
  input  logic [BURST_W-1:0]            burst_num,
  input  logic                          slave_valid,
  input  logic                          rx_data,
  input  logic                          data_ready,
  output logic                          master_ready,
  output logic                          new_rx,
  output logic [DATA_WIDTH-1:0]         data,
  output logic                          data_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          rx_done,
  output logic                          timeout_err
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);
  localparam logic [TCW-1:0] TO_LAST  = TCW'(TIMEOUT - 1);
  localparam logic [AW:0]    DEPTH    = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RECV, DONE} state_t;

  state_t                state;
  logic [BCW-1:0]        bit_cnt;
  logic [BCW-1:0]        bit_idx;
  logic [BURST_W-1:0]    words_left;
  logic [TCW-1:0]        tcnt;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_d;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic [AW:0]           level;
  logic                  push;
  logic                  pop;

  // Each sample is written straight into its final bit position, so the
  // assembled word on the last bit already includes the incoming bit.
  assign bit_idx = (MSB_FIRST != 0) ? (LAST_BIT - bit_cnt) : bit_cnt;

  always_comb begin
    shift_d = shift_q;
    shift_d[bit_idx] = rx_data;
  end

  assign push         = (state == RECV) && (bit_cnt == LAST_BIT);
  assign data_valid   = (level != '0);
  assign pop          = data_valid && data_ready;
  assign master_ready = (state == WAIT) && (level < DEPTH);
  assign fifo_level   = level;
  assign data         = data_valid ? mem[rptr] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      words_left  <= '0;
      tcnt        <= '0;
      shift_q     <= '0;
      new_rx      <= 1'b0;
      rx_done     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      new_rx      <= push;
      rx_done     <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_done && instruction == 2'b11) begin
            words_left <= burst_num;
            tcnt       <= '0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (slave_valid) begin
            tcnt <= '0;
            if (master_ready) begin
              bit_cnt <= '0;
              state   <= RECV;
            end
          end else if (tcnt == TO_LAST) begin
            timeout_err <= 1'b1;
            tcnt        <= '0;
            state       <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RECV: begin
          shift_q <= shift_d;
          bit_cnt <= bit_cnt + 1'b1;
          if (push) begin
            bit_cnt <= '0;
            tcnt    <= '0;
            if (words_left == '0) begin
              state <= DONE;
            end else begin
              words_left <= words_left - 1'b1;
              state      <= WAIT;
            end
          end
        end
        DONE: begin
          rx_done <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pointers are AW bits wide, so they wrap modulo the power-of-two depth.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= shift_d;
  end

endmodule

// File: tb/tb_master_in_burst.sv
// tb/tb_master_in_burst.sv - directed vector bench for master_in_burst
module tb_master_in_burst;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tx_done = 1'b0;
  logic [1:0]  instruction = 2'b00;
  logic [11:0] burst_num = 12'd0;
  logic        slave_valid = 1'b0;
  logic        rx_data = 1'b0;
  logic        data_ready = 1'b0;

  logic       master_ready0, new_rx0, data_valid0, rx_done0, timeout_err0;
  logic [7:0] data0;
  logic [2:0] fifo_level0;
  logic       master_ready1, new_rx1, data_valid1, rx_done1, timeout_err1;
  logic [7:0] data1;
  logic [2:0] fifo_level1;

  master_in_burst #(.DATA_WIDTH(8), .BURST_W(12), .FIFO_DEPTH(4), .MSB_FIRST(0), .TIMEOUT(16)) dut0 (
    .clk(clk), .reset(reset), .tx_done(tx_done), .instruction(instruction), .burst_num(burst_num),
    .slave_valid(slave_valid), .rx_data(rx_data), .data_ready(data_ready),
    .master_ready(master_ready0), .new_rx(new_rx0), .data(data0), .data_valid(data_valid0),
    .fifo_level(fifo_level0), .rx_done(rx_done0), .timeout_err(timeout_err0)
  );

  master_in_burst #(.DATA_WIDTH(8), .BURST_W(12), .FIFO_DEPTH(4), .MSB_FIRST(1), .TIMEOUT(16)) dut1 (
    .clk(clk), .reset(reset), .tx_done(tx_done), .instruction(instruction), .burst_num(burst_num),
    .slave_valid(slave_valid), .rx_data(rx_data), .data_ready(data_ready),
    .master_ready(master_ready1), .new_rx(new_rx1), .data(data1), .data_valid(data_valid1),
    .fifo_level(fifo_level1), .rx_done(rx_done1), .timeout_err(timeout_err1)
  );

  always #5 clk = ~clk;

  // seq is the serial stream with the leftmost bit sent first
  typedef struct {
    logic [7:0] seq;
    logic [7:0] exp_lsb;
    logic [7:0] exp_msb;
  } vec_t;

  vec_t       vecs [6];
  int         n_vec = 0;
  int         n_err = 0;
  logic       mon_en = 1'b0;
  logic [7:0] exp_q [$];
  int         pops = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && data_valid0 && data_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL pop_extra: got %0h expected no pop", data0);
      end else begin
        chk("pop_order", data0, exp_q.pop_front());
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_read(input logic [11:0] bn);
    tx_done = 1'b1; instruction = 2'b11; burst_num = bn;
    tick();
    tx_done = 1'b0; instruction = 2'b00; burst_num = 12'hABC;
    chk("enter_wait_ready", master_ready0, 1);
  endtask

  task automatic send_word(input logic [7:0] seq);
    int guard;
    guard = 0;
    slave_valid = 1'b1;
    while (!master_ready0 && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: got master_ready=0 expected 1 within 50 cycles");
    end
    tick();
    slave_valid = 1'b0;
    tx_done = 1'b1; instruction = 2'b11;
    for (int i = 0; i < 8; i++) begin
      rx_data = seq[7-i];
      tick();
    end
    tx_done = 1'b0; instruction = 2'b00; rx_data = 1'b0;
    chk("new_rx_pulse", new_rx0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int spur;
    vecs[0] = '{8'b01101011, 8'hD6, 8'h6B};
    vecs[1] = '{8'b10000000, 8'h01, 8'h80};
    vecs[2] = '{8'b11110000, 8'h0F, 8'hF0};
    vecs[3] = '{8'b10100101, 8'hA5, 8'hA5};
    vecs[4] = '{8'b00000001, 8'h80, 8'h01};
    vecs[5] = '{8'b11001010, 8'h53, 8'hCA};

    repeat (2) tick();
    chk("rst_master_ready", master_ready0, 0);
    chk("rst_new_rx", new_rx0, 0);
    chk("rst_data_valid", data_valid0, 0);
    chk("rst_rx_done", rx_done0, 0);
    chk("rst_timeout_err", timeout_err0, 0);
    chk("rst_data", data0, 0);
    chk("rst_level", fifo_level0, 0);
    @(negedge clk) reset = 1'b1;
    tick();

    tx_done = 1'b1; instruction = 2'b01;
    tick();
    tx_done = 1'b0; instruction = 2'b00;
    chk("ignored_cmd_ready", master_ready0, 0);
    slave_valid = 1'b1;
    repeat (12) tick();
    slave_valid = 1'b0;
    chk("ignored_cmd_new_rx", new_rx0, 0);
    chk("ignored_cmd_level", fifo_level0, 0);

    for (int i = 0; i < 6; i++) begin
      start_read(12'd0);
      send_word(vecs[i].seq);
      chk("lsb_data", data0, vecs[i].exp_lsb);
      chk("msb_data", data1, vecs[i].exp_msb);
      chk("single_valid", data_valid0, 1);
      chk("single_level", fifo_level0, 1);
      chk("rx_done_early", rx_done0, 0);
      tick();
      chk("rx_done", rx_done0, 1);
      chk("new_rx_single", new_rx0, 0);
      chk("idle_ready", master_ready0, 0);
      tick();
      chk("rx_done_pulse", rx_done0, 0);
      data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
      chk("drained_level", fifo_level0, 0);
      chk("drained_data", data0, 0);
    end

    mon_en = 1'b1; data_ready = 1'b1; pops = 0;
    start_read(12'd2);
    exp_q.push_back(8'h5E); send_word(8'b01111010);
    exp_q.push_back(8'hD4); send_word(8'b00101011);
    chk("burst_mid_rx_done", rx_done0, 0);
    exp_q.push_back(8'hDE); send_word(8'b01111011);
    tick();
    chk("burst_rx_done", rx_done0, 1);
    chk("burst_level", fifo_level0, 0);
    chk("burst_pops", pops, 3);
    mon_en = 1'b0; data_ready = 1'b0; pops = 0;

    mon_en = 1'b1;
    start_read(12'd5);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(vecs[i].exp_lsb);
      send_word(vecs[i].seq);
    end
    chk("bp_level", fifo_level0, 4);
    chk("bp_ready", master_ready0, 0);
    slave_valid = 1'b1;
    repeat (3) tick();
    chk("bp_stall_ready", master_ready0, 0);
    chk("bp_stall_new_rx", new_rx0, 0);
    chk("bp_stall_level", fifo_level0, 4);
    data_ready = 1'b1;
    for (int i = 4; i < 6; i++) begin
      exp_q.push_back(vecs[i].exp_lsb);
      send_word(vecs[i].seq);
    end
    tick();
    chk("bp_rx_done", rx_done0, 1);
    repeat (6) tick();
    chk("bp_pops", pops, 6);
    chk("bp_level_end", fifo_level0, 0);
    mon_en = 1'b0; data_ready = 1'b0; pops = 0;

    start_read(12'd1);
    send_word(vecs[2].seq);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("timeout_early", timeout_err0, 0);
    end
    tick();
    chk("timeout_pulse", timeout_err0, 1);
    chk("timeout_idle_ready", master_ready0, 0);
    chk("timeout_no_done", rx_done0, 0);
    tick();
    chk("timeout_pulse_end", timeout_err0, 0);
    chk("timeout_retain_level", fifo_level0, 1);
    chk("timeout_retain_data", data0, 8'h0F);

    start_read(12'd0);
    slave_valid = 1'b1;
    tick();
    slave_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx_data = vecs[0].seq[7-i];
      tick();
    end
    #2 reset = 1'b0;
    #1;
    chk("midrst_master_ready", master_ready0, 0);
    chk("midrst_new_rx", new_rx0, 0);
    chk("midrst_data_valid", data_valid0, 0);
    chk("midrst_rx_done", rx_done0, 0);
    chk("midrst_timeout_err", timeout_err0, 0);
    chk("midrst_data", data0, 0);
    chk("midrst_level", fifo_level0, 0);
    rx_data = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    spur = 0;
    repeat (12) begin
      tick();
      if (new_rx0 || rx_done0) spur++;
    end
    rx_data = 1'b0;
    chk("post_reset_spurious", spur, 0);
    start_read(12'd0);
    send_word(vecs[0].seq);
    chk("post_reset_data", data0, 8'hD6);
    chk("post_reset_level", fifo_level0, 1);
    tick();
    chk("post_reset_rx_done", rx_done0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
